// File: rtl/miriscv_decode_pkg.sv
// Shared decode/issue types: issue FSM state encoding and pending-writeback queue entry.
package miriscv_decode_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MDU_BUSY    = 2'd1,
        FENCE_DRAIN = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic       wb;
        logic [4:0] rd;
    } pend_entry_t;

    // x0 is hard-wired to zero, so it never creates a load-use dependency.
    function automatic logic rd_hit(input pend_entry_t e, input logic v, input logic [4:0] addr);
        return v & e.wb & (e.rd == addr) & (addr != 5'd0);
    endfunction

endpackage

// File: rtl/miriscv_issue_ctrl_if.sv
// Decode/LSU/MDU handshake bundle between the decoder side and the issue controller.
interface miriscv_issue_ctrl_if;
    logic       d_valid_i;
    logic [4:0] d_rs1_addr_i;
    logic [4:0] d_rs2_addr_i;
    logic [4:0] d_rd_addr_i;
    logic       d_rs1_re_i;
    logic       d_rs2_re_i;
    logic       d_wb_we_i;
    logic       d_mem_req_i;
    logic       d_load_i;
    logic       d_mdu_req_i;
    logic       d_fence_i;
    logic       d_illegal_i;
    logic       ex_redirect_i;
    logic       lsu_req_ready_i;
    logic       lsu_rsp_valid_i;
    logic       mdu_done_i;
    logic       issue_o;
    logic       d_stall_o;
    logic       flush_o;
    logic       mdu_start_o;
    logic       trap_o;
    logic       busy_o;

    modport master (
        output d_valid_i, d_rs1_addr_i, d_rs2_addr_i, d_rd_addr_i,
        output d_rs1_re_i, d_rs2_re_i, d_wb_we_i,
        output d_mem_req_i, d_load_i, d_mdu_req_i, d_fence_i, d_illegal_i,
        output ex_redirect_i, lsu_req_ready_i, lsu_rsp_valid_i, mdu_done_i,
        input  issue_o, d_stall_o, flush_o, mdu_start_o, trap_o, busy_o
    );

    modport slave (
        input  d_valid_i, d_rs1_addr_i, d_rs2_addr_i, d_rd_addr_i,
        input  d_rs1_re_i, d_rs2_re_i, d_wb_we_i,
        input  d_mem_req_i, d_load_i, d_mdu_req_i, d_fence_i, d_illegal_i,
        input  ex_redirect_i, lsu_req_ready_i, lsu_rsp_valid_i, mdu_done_i,
        output issue_o, d_stall_o, flush_o, mdu_start_o, trap_o, busy_o
    );
endinterface

// File: rtl/miriscv_issue_ctrl_chk.sv
// Protocol checker for the issue controller: LSU responses must not arrive with nothing pending.
module miriscv_issue_ctrl_chk (
    input logic clk_i,
    input logic rst_i,
    input logic pop,
    input logic empty
);
    pop_on_empty_a: assert property (@(posedge clk_i) disable iff (rst_i) !(pop && empty));
endmodule

// File: rtl/miriscv_pend_queue.sv
// In-order pending-writeback FIFO for LSU transactions with per-entry rd match vectors.
module miriscv_pend_queue
    import miriscv_decode_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  pend_entry_t      push_entry,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic             full,
    output logic             empty,
    output logic             last,
    output logic [DEPTH-1:0] head_mask,
    output logic [DEPTH-1:0] rs1_match,
    output logic [DEPTH-1:0] rs2_match
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    pend_entry_t      entry_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full   = (count_r == CNT_W'(DEPTH));
    assign empty  = (count_r == {CNT_W{1'b0}});
    assign last   = (count_r == CNT_W'(1));
    // A pop on an empty queue is dropped; the checker flags it.
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    // Head one-hot and load-use match vectors against the two source addresses.
    always_comb begin
        head_mask = {DEPTH{1'b0}};
        rs1_match = {DEPTH{1'b0}};
        rs2_match = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            head_mask[i] = (rd_ptr_r == PTR_W'(i));
            rs1_match[i] = rd_hit(entry_r[i], valid_r[i], rs1_addr);
            rs2_match[i] = rd_hit(entry_r[i], valid_r[i], rs2_addr);
        end
    end

    // Pointer, valid-bit, entry and occupancy update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '{wb: 1'b0, rd: 5'd0};
            end
        end else begin
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= next_ptr(rd_ptr_r);
            end
            if (push_s) begin
                valid_r[wr_ptr_r] <= 1'b1;
                entry_r[wr_ptr_r] <= push_entry;
                wr_ptr_r          <= next_ptr(wr_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/miriscv_issue_ctrl.sv
// Issue/hazard controller between decode and execute: load-use, MDU, FENCE drain, illegal trap.
// Optional MIRISCV_LOAD_BYPASS_EN lets a dependent instruction issue in the load response cycle.
module miriscv_issue_ctrl
    import miriscv_decode_pkg::*;
#(
    parameter int LSU_OUTSTANDING = 2
) (
    input logic                 clk_i,
    input logic                 rst_i,
    miriscv_issue_ctrl_if.slave bus
);
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_MDU   = MDU_BUSY;
    localparam logic [1:0] ST_FENCE = FENCE_DRAIN;
`ifdef MIRISCV_LOAD_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic [1:0]                 state_r;
    logic [1:0]                 state_next_s;
    logic                       q_full_s;
    logic                       q_empty_s;
    logic                       q_last_s;
    logic [LSU_OUTSTANDING-1:0] q_head_mask_s;
    logic [LSU_OUTSTANDING-1:0] q_rs1_match_s;
    logic [LSU_OUTSTANDING-1:0] q_rs2_match_s;
    logic [LSU_OUTSTANDING-1:0] excl_s;
    logic                       hazard_s;
    logic                       run_s;
    logic                       mem_ok_s;
    logic                       fence_ok_s;
    logic                       issue_s;
    logic                       trap_s;
    logic                       flush_s;
    logic                       push_s;
    logic                       fence_wait_s;
    logic                       drained_s;
    pend_entry_t                push_entry_s;

    assign push_entry_s.wb = bus.d_load_i & bus.d_wb_we_i & (bus.d_rd_addr_i != 5'd0);
    assign push_entry_s.rd = bus.d_rd_addr_i;

    miriscv_pend_queue #(.DEPTH(LSU_OUTSTANDING)) u_pend_queue (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (push_s),
        .pop        (bus.lsu_rsp_valid_i),
        .push_entry (push_entry_s),
        .rs1_addr   (bus.d_rs1_addr_i),
        .rs2_addr   (bus.d_rs2_addr_i),
        .full       (q_full_s),
        .empty      (q_empty_s),
        .last       (q_last_s),
        .head_mask  (q_head_mask_s),
        .rs1_match  (q_rs1_match_s),
        .rs2_match  (q_rs2_match_s)
    );

    miriscv_issue_ctrl_chk u_chk (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .pop   (bus.lsu_rsp_valid_i),
        .empty (q_empty_s)
    );

    // With bypass, the head entry being answered this cycle is forwarded by the datapath.
    assign excl_s   = q_head_mask_s & {LSU_OUTSTANDING{BYPASS & bus.lsu_rsp_valid_i}};
    assign hazard_s = (bus.d_rs1_re_i & |(q_rs1_match_s & ~excl_s))
                    | (bus.d_rs2_re_i & |(q_rs2_match_s & ~excl_s));

    assign run_s      = (state_r == ST_RUN);
    // A response in the same cycle deliberately does not free a full queue.
    assign mem_ok_s   = ~bus.d_mem_req_i | (~q_full_s & bus.lsu_req_ready_i);
    assign fence_ok_s = ~bus.d_fence_i | q_empty_s;

    assign issue_s = ~rst_i & bus.d_valid_i & ~bus.ex_redirect_i & ~bus.d_illegal_i & run_s
                   & ~hazard_s & mem_ok_s & fence_ok_s;
    assign trap_s  = ~rst_i & bus.d_valid_i & bus.d_illegal_i & run_s & ~bus.ex_redirect_i;
    assign flush_s = ~rst_i & (bus.ex_redirect_i | trap_s);
    assign push_s  = issue_s & bus.d_mem_req_i;

    assign bus.issue_o     = issue_s;
    assign bus.flush_o     = flush_s;
    assign bus.trap_o      = trap_s;
    assign bus.mdu_start_o = issue_s & bus.d_mdu_req_i;
    assign bus.d_stall_o   = ~rst_i & bus.d_valid_i & ~issue_s & ~flush_s;
    assign bus.busy_o      = ~q_empty_s | (state_r == ST_MDU);

    assign fence_wait_s = run_s & bus.d_valid_i & bus.d_fence_i & ~bus.d_illegal_i
                        & ~bus.ex_redirect_i & ~q_empty_s;
    // Leave the drain on the edge that retires the last response so the fence issues next cycle.
    assign drained_s    = q_empty_s | (q_last_s & bus.lsu_rsp_valid_i);

    // Issue FSM next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (issue_s && bus.d_mdu_req_i) begin
                    state_next_s = ST_MDU;
                end else if (fence_wait_s) begin
                    state_next_s = ST_FENCE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_MDU: begin
                if (bus.mdu_done_i) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_MDU;
                end
            end
            ST_FENCE: begin
                if (bus.ex_redirect_i || drained_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_FENCE;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // Issue FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

endmodule

// File: doc/miriscv_issue_ctrl.md
# miriscv_issue_ctrl

Issue/hazard controller between the miriscv decoder and the execute stage. It decides each cycle whether the decoded instruction advances, stalls or is killed. It tracks outstanding LSU transactions in a small in-order pending-writeback queue, blocks issue during a multicycle MDU operation, drains memory before a FENCE, and converts illegal instructions into a trap request.

## Interface
- LSU_OUTSTANDING, default 2: maximum in-flight LSU transactions (1..4).
- clk_i  in  1  core clock.
- rst_i  in  1  reset, asynchronous, active-high.
- d_valid_i  in  1  decode holds a valid instruction.
- d_rs1_addr_i, d_rs2_addr_i, d_rd_addr_i  in  5 each  decoded register addresses.
- d_rs1_re_i, d_rs2_re_i, d_wb_we_i  in  1 each  decoder read/write enables.
- d_mem_req_i, d_load_i, d_mdu_req_i, d_fence_i, d_illegal_i  in  1 each  decoder class flags.
- ex_redirect_i  in  1  execute resolved a taken branch/jump this cycle.
- lsu_req_ready_i  in  1  LSU can accept a request.
- lsu_rsp_valid_i  in  1  LSU returns one response, in order.
- mdu_done_i  in  1  MDU result valid.
- issue_o  out  1  decode instruction moves to execute this cycle.
- d_stall_o  out  1  hold fetch/decode.
- flush_o  out  1  kill fetch/decode contents.
- mdu_start_o  out  1  MDU start pulse.
- trap_o  out  1  illegal-instruction trap request, 1-cycle pulse.
- busy_o  out  1  any LSU transaction outstanding or MDU busy.

## Operation
- States: RUN, MDU_BUSY, FENCE_DRAIN.
- Pending queue: LSU_OUTSTANDING entries of {wb, rd}. Every issued mem_req pushes an entry, with wb = d_load_i & d_wb_we_i & (rd != 0). Each lsu_rsp_valid_i pops the head.
- Load-use hazard: d_rs1_re_i & (rs1 matches any valid entry with wb=1), or the same test on rs2. x0 never matches.
- Issue conditions, all required:
  - d_valid_i, !ex_redirect_i, !d_illegal_i, state RUN, no hazard.
  - If d_mem_req_i: queue not full and lsu_req_ready_i. A response arriving in the same cycle does not relieve a full queue.
  - If d_fence_i: queue empty.
- Priority: ex_redirect_i > trap > stall.
- ex_redirect_i: flush_o=1, issue_o=0.
  - FENCE_DRAIN goes to RUN; the killed fence is not executed.
  - MDU_BUSY is unchanged.
  - Queue pops still happen.
- Illegal: d_valid_i & d_illegal_i & state RUN & !ex_redirect_i gives trap_o=1, flush_o=1, issue_o=0. The hazard does not delay the trap.
- MDU: issuing d_mdu_req_i gives mdu_start_o=1 in that cycle, then RUN→MDU_BUSY. mdu_done_i returns to RUN, and issue is allowed from the following cycle. mdu_done_i in RUN is ignored.
- FENCE: d_fence_i with queue non-empty in RUN gives RUN→FENCE_DRAIN. When the queue is empty it returns to RUN, and the fence issues on the next cycle.
- d_stall_o = d_valid_i & !issue_o & !flush_o.
- busy_o = queue non-empty | state==MDU_BUSY.
- Queue count update:
  - Simultaneous push and pop leaves the count unchanged.
  - Pop on empty is a protocol error. It is ignored, and a simulation assertion fires.

## Timing
- issue_o, d_stall_o, flush_o, trap_o and mdu_start_o are combinational from inputs and registered state. Zero latency.
- State, queue and count update on the rising clk_i edge.
- While rst_i is asserted:
  - All outputs are 0.
  - State is RUN, queue empty, count 0.
  - Reset mid-operation drops all pending entries with no response expected.
- A load issued in cycle N with rd=x5: a dependent instruction stalls until the cycle after the response pop (without the configuration macro).

## Configuration
- MIRISCV_LOAD_BYPASS_EN defined: the head entry is excluded from the hazard test in the cycle lsu_rsp_valid_i=1. The dependent instruction issues in the response cycle, with the writeback forwarded by the datapath.
- Not defined: the hazard clears one cycle after the pop.

## Structure
- miriscv_decode_pkg gets:
  - issue_state_t enum {RUN, MDU_BUSY, FENCE_DRAIN}.
  - pend_entry_t struct {logic wb; logic [4:0] rd;}.
- Sub-module miriscv_pend_queue: circular FIFO with push/pop, full/empty outputs, and a per-entry match vector against two read addresses.

## Test plan
- lw x5 issues; next add x6,x5,x1 with the response 3 cycles later. Without the macro, d_stall_o=1 for 4 cycles, then issue_o=1. With it, stall lasts 3 cycles.
- LSU_OUTSTANDING=2: three back-to-back sw with no responses. Third has d_stall_o=1 until the first lsu_rsp_valid_i, then issues the next cycle.
- mul issues: mdu_start_o pulses once, busy_o=1. mdu_done_i arrives after 5 cycles; the next add issues the cycle after mdu_done_i.
- fence with 2 loads pending: FENCE_DRAIN. After the second response, fence issue_o=1 one cycle later.
- ex_redirect_i during FENCE_DRAIN: flush_o=1, state RUN, fence not issued, queue keeps 1 pending entry.
- d_illegal_i=1 with d_valid_i: trap_o=1 and flush_o=1 for exactly 1 cycle, issue_o=0. rst_i mid-MDU gives all outputs 0 and busy_o=0.
